contador_regressivo: RTL and testbench

4-digit BCD countdown timer, the down-counting counterpart of the stopwatch chain. Loads a BCD preset from switches, then decrements one count per prescaled tick. Raises an alarm when it reaches 0000. Takes the already-conditioned control pulses from the input block and feeds its digit outputs to the existing 7-segment `display` decoders.

---
 rtl/timer_pkg.sv | 27 ++
 rtl/digito_regressivo.sv | 34 +++
 rtl/contador_regressivo.sv | 132 +++++++++++++
 tb/tb_contador_regressivo.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the BCD countdown timer (contador_regressivo).
// Provides the FSM state encoding, BCD limits, digit count, the default
// prescaler division and a per-nibble clamp helper for preset values.
package timer_pkg;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    CONTANDO = 2'd1,
    PAUSADO  = 2'd2,
    FIM      = 2'd3
  } estado_t;

  localparam logic [3:0] BCD_MAX         = 4'd9;
  localparam int         NUM_DIGITOS     = 4;
  localparam int         TICK_DIV_PADRAO = 500000;

  // Forces every nibble of a 4-digit preset into the 0..9 range.
  function automatic logic [15:0] clamp_bcd(input logic [15:0] valor);
    logic [15:0] res;
    res = valor;
    for (int i = 0; i < NUM_DIGITOS; i++) begin
      if (valor[4*i +: 4] > BCD_MAX) res[4*i +: 4] = BCD_MAX;
    end
    return res;
  endfunction

endpackage

// File: rtl/digito_regressivo.sv
// One BCD digit of the countdown borrow chain.
// Ports:
//   clock, reset      rising-edge clock, synchronous active-low reset
//   enable            decrement strobe shared by the whole chain
//   borrow_in         this digit must decrement (chain input)
//   load, valor_carga parallel load of an already-clamped BCD value
//   digito            current digit value
//   borrow_out        borrow_in and this digit is 0 (it wraps to 9)
module digito_regressivo
  import timer_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       borrow_in,
  input  logic       load,
  input  logic [3:0] valor_carga,
  output logic [3:0] digito,
  output logic       borrow_out
);

  always_ff @(posedge clock) begin
    if (!reset) begin
      digito <= 4'd0;
    end else if (load) begin
      digito <= valor_carga;
    end else if (enable && borrow_in) begin
      digito <= (digito == 4'd0) ? BCD_MAX : digito - 4'd1;
    end
  end

  assign borrow_out = borrow_in & (digito == 4'd0);

endmodule

// File: rtl/contador_regressivo.sv
// 4-digit BCD countdown timer. Loads a clamped BCD preset, decrements once
// per prescaled tick, pulses fim and latches alarme on reaching 0000.
// Ports:
//   clock, reset               rising-edge clock, synchronous active-low reset
//   carregar, valor_carga      load pulse and BCD preset ([15:12] = MSD)
//   contar, pausar, parar      start/resume, pause, stop (restore preset)
//   digito0..digito3           BCD digits, digito0 least significant
//   rodando                    high while counting
//   fim                        one-cycle pulse on reaching 0000
//   alarme                     level, held until parar/carregar/reset
//
// state    | meaning
// OCIOSO   | idle, digits hold preset or loaded value
// CONTANDO | prescaler running, digits decrement on each tick
// PAUSADO  | prescaler and digits frozen, resumable
// FIM      | reached 0000, alarm raised, waits for parar/carregar
module contador_regressivo
  import timer_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_PADRAO,
  parameter int PRE_W    = 19
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        carregar,
  input  logic [15:0] valor_carga,
  input  logic        contar,
  input  logic        pausar,
  input  logic        parar,
  output logic [3:0]  digito0,
  output logic [3:0]  digito1,
  output logic [3:0]  digito2,
  output logic [3:0]  digito3,
  output logic        rodando,
  output logic        fim,
  output logic        alarme
);

  estado_t              state_q, state_d;
  logic [PRE_W-1:0]     pre_q, pre_d;
  logic [15:0]          preset_q, preset_d;
  logic                 alarme_d, fim_d;
  logic                 carga_en, dec_en;
  logic [15:0]          carga_val, digitos, clamped;
  logic [NUM_DIGITOS:0] borrow;
  logic                 tick, todos_zero, vai_zerar;

  // With borrow[0] tied high, the chain's final borrow is set exactly when
  // every digit is 0, so it doubles as the zero detector.
  assign borrow[0]  = 1'b1;
  assign todos_zero = borrow[NUM_DIGITOS];
  assign vai_zerar  = (digitos == 16'h0001);
  assign tick       = (pre_q == PRE_W'(TICK_DIV - 1));
  assign clamped    = clamp_bcd(valor_carga);

  for (genvar i = 0; i < NUM_DIGITOS; i++) begin : g_dig
    digito_regressivo u_dig (
      .clock       (clock),
      .reset       (reset),
      .enable      (dec_en),
      .borrow_in   (borrow[i]),
      .load        (carga_en),
      .valor_carga (carga_val[4*i +: 4]),
      .digito      (digitos[4*i +: 4]),
      .borrow_out  (borrow[i+1])
    );
  end

  always_comb begin
    state_d   = state_q;
    pre_d     = pre_q;
    preset_d  = preset_q;
    alarme_d  = alarme;
    fim_d     = 1'b0;
    carga_en  = 1'b0;
    carga_val = preset_q;
    dec_en    = 1'b0;
    if (parar) begin
      state_d  = OCIOSO;
      carga_en = 1'b1;
      pre_d    = '0;
      alarme_d = 1'b0;
    end else if (carregar && state_q != CONTANDO) begin
      state_d   = OCIOSO;
      preset_d  = clamped;
      carga_en  = 1'b1;
      carga_val = clamped;
      pre_d     = '0;
      alarme_d  = 1'b0;
    end else if (pausar && state_q == CONTANDO) begin
      state_d = PAUSADO;
    end else if (contar && !todos_zero &&
                 (state_q == OCIOSO || state_q == PAUSADO)) begin
      state_d = CONTANDO;
      if (state_q == OCIOSO) pre_d = '0;
    end else if (state_q == CONTANDO) begin
      pre_d = tick ? '0 : pre_q + PRE_W'(1);
      if (tick) begin
        dec_en = 1'b1;
        if (vai_zerar) begin
          state_d  = FIM;
          fim_d    = 1'b1;
          alarme_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= OCIOSO;
      pre_q    <= '0;
      preset_q <= 16'h0000;
      rodando  <= 1'b0;
      fim      <= 1'b0;
      alarme   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      preset_q <= preset_d;
      rodando  <= (state_d == CONTANDO);
      fim      <= fim_d;
      alarme   <= alarme_d;
    end
  end

  assign digito0 = digitos[3:0];
  assign digito1 = digitos[7:4];
  assign digito2 = digitos[11:8];
  assign digito3 = digitos[15:12];

endmodule

// File: tb/tb_contador_regressivo.sv
module tb_contador_regressivo;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        carregar = 1'b0;
  logic [15:0] valor_carga = 16'h0000;
  logic        contar = 1'b0;
  logic        pausar = 1'b0;
  logic        parar = 1'b0;
  logic [3:0]  digito0, digito1, digito2, digito3;
  logic        rodando, fim, alarme;

  contador_regressivo #(.TICK_DIV(4), .PRE_W(3)) dut (
    .clock       (clock),
    .reset       (reset),
    .carregar    (carregar),
    .valor_carga (valor_carga),
    .contar      (contar),
    .pausar      (pausar),
    .parar       (parar),
    .digito0     (digito0),
    .digito1     (digito1),
    .digito2     (digito2),
    .digito3     (digito3),
    .rodando     (rodando),
    .fim         (fim),
    .alarme      (alarme)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int          at;
    logic [15:0] dig;
    logic        rod;
    logic        fim;
    logic        alm;
    string       nm;
  } exp_t;

  exp_t exp_q[$];
  int   fim_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  exp_t e;
  logic [15:0] dig_now;

  // Monitor: pops expectations whose cycle has come, and checks every fim pulse.
  always @(negedge clock) begin
    dig_now = {digito3, digito2, digito1, digito0};
    while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
      e = exp_q.pop_front();
      n_vec++;
      if (e.at != cyc) begin
        n_err++;
        $display("FAIL %s: expectation for cycle %0d not checked (now %0d)", e.nm, e.at, cyc);
      end else if (dig_now !== e.dig || rodando !== e.rod || fim !== e.fim || alarme !== e.alm) begin
        n_err++;
        $display("FAIL %s cyc=%0d: got dig=%h rod=%b fim=%b alm=%b, want dig=%h rod=%b fim=%b alm=%b",
                 e.nm, cyc, dig_now, rodando, fim, alarme, e.dig, e.rod, e.fim, e.alm);
      end
    end
    while (fim_q.size() > 0 && fim_q[0] < cyc) begin
      n_vec++;
      n_err++;
      $display("FAIL fim_pulse: expected at cycle %0d, not seen", fim_q.pop_front());
    end
    if (fim) begin
      n_vec++;
      if (fim_q.size() > 0 && fim_q[0] == cyc) begin
        void'(fim_q.pop_front());
      end else begin
        n_err++;
        $display("FAIL fim_pulse: unexpected fim at cycle %0d", cyc);
      end
    end
  end

  task automatic chk(input int off, input logic [15:0] d, input logic r, f, a, input string nm);
    exp_q.push_back('{at: cyc + off, dig: d, rod: r, fim: f, alm: a, nm: nm});
  endtask

  task automatic drive(input logic ca, input logic [15:0] v, input logic co, pa, pr);
    carregar = ca; valor_carga = v; contar = co; pausar = pa; parar = pr;
    @(negedge clock);
    carregar = 1'b0; contar = 1'b0; pausar = 1'b0; parar = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset held for two edges, then checked on a third
    idle(2);
    chk(1, 16'h0000, 0, 0, 0, "reset");
    idle(1);
    reset = 1'b1;

    // contar with 0000 is ignored
    chk(1, 16'h0000, 0, 0, 0, "contar_zero");
    chk(3, 16'h0000, 0, 0, 0, "contar_zero_hold");
    drive(0, 16'h0, 1, 0, 0);
    idle(3);

    // basic run from 0012 to 0000
    chk(1, 16'h0012, 0, 0, 0, "load_0012");
    drive(1, 16'h0012, 0, 0, 0);
    chk(1,  16'h0012, 1, 0, 0, "run_start");
    chk(4,  16'h0012, 1, 0, 0, "run_pre_tick");
    chk(5,  16'h0011, 1, 0, 0, "run_first_dec");
    chk(9,  16'h0010, 1, 0, 0, "run_0010");
    chk(13, 16'h0009, 1, 0, 0, "run_borrow_0009");
    chk(48, 16'h0001, 1, 0, 0, "run_0001");
    chk(49, 16'h0000, 0, 1, 1, "run_fim");
    chk(50, 16'h0000, 0, 0, 1, "alarm_held");
    chk(60, 16'h0000, 0, 0, 1, "alarm_held_late");
    fim_q.push_back(cyc + 49);
    drive(0, 16'h0, 1, 0, 0);
    idle(60);

    // contar ignored in FIM, then carregar clears the alarm
    chk(2, 16'h0000, 0, 0, 1, "fim_contar_ignored");
    drive(0, 16'h0, 1, 0, 0);
    idle(1);
    chk(1, 16'h0003, 0, 0, 0, "fim_load_clears");
    drive(1, 16'h0003, 0, 0, 0);

    // borrow through all digits
    chk(1, 16'h1000, 0, 0, 0, "load_1000");
    drive(1, 16'h1000, 0, 0, 0);
    chk(1, 16'h1000, 1, 0, 0, "run_1000");
    chk(5, 16'h0999, 1, 0, 0, "borrow_chain");
    drive(0, 16'h0, 1, 0, 0);
    idle(6);
    // carregar ignored while counting; counting continues
    chk(1, 16'h0999, 1, 0, 0, "load_ignored");
    chk(2, 16'h0998, 1, 0, 0, "load_ignored_run");
    drive(1, 16'h0055, 0, 0, 0);
    idle(1);
    // parar mid-count restores preset
    chk(1, 16'h1000, 0, 0, 0, "parar_restore");
    drive(0, 16'h0, 0, 0, 1);

    // clamping
    chk(1, 16'h0099, 0, 0, 0, "clamp_00AF");
    drive(1, 16'h00AF, 0, 0, 0);
    chk(1, 16'h9999, 0, 0, 0, "clamp_FA9B");
    drive(1, 16'hFA9B, 0, 0, 0);

    // pause / resume with prescaler retained
    chk(1, 16'h0005, 0, 0, 0, "load_0005");
    drive(1, 16'h0005, 0, 0, 0);
    drive(0, 16'h0, 1, 0, 0);
    idle(10);
    chk(1,  16'h0003, 0, 0, 0, "pause");
    chk(20, 16'h0003, 0, 0, 0, "pause_frozen");
    drive(0, 16'h0, 0, 1, 0);
    idle(20);
    chk(1, 16'h0003, 1, 0, 0, "resume");
    chk(2, 16'h0003, 1, 0, 0, "resume_pre3");
    chk(3, 16'h0002, 1, 0, 0, "resume_dec");
    drive(0, 16'h0, 1, 0, 0);
    idle(5);
    // pausar on the tick cycle suppresses the decrement
    chk(1, 16'h0002, 0, 0, 0, "pause_on_tick");
    drive(0, 16'h0, 0, 1, 0);
    chk(1, 16'h0002, 1, 0, 0, "resume_at_tick");
    chk(2, 16'h0001, 1, 0, 0, "resume_tick_dec");
    drive(0, 16'h0, 1, 0, 0);
    idle(1);
    // parar and contar together: parar wins
    chk(1, 16'h0005, 0, 0, 0, "parar_contar");
    chk(3, 16'h0005, 0, 0, 0, "parar_contar_hold");
    drive(0, 16'h0, 1, 0, 1);
    idle(3);

    // reset mid-count at 0007
    chk(1, 16'h0007, 0, 0, 0, "load_0007");
    drive(1, 16'h0007, 0, 0, 0);
    chk(1, 16'h0007, 1, 0, 0, "run_0007");
    drive(0, 16'h0, 1, 0, 0);
    chk(1, 16'h0000, 0, 0, 0, "reset_mid");
    reset = 1'b0;
    idle(1);
    reset = 1'b1;
    // preset was cleared by reset: parar restores 0000
    chk(1, 16'h0000, 0, 0, 0, "preset_cleared");
    drive(0, 16'h0, 0, 0, 1);

    idle(5);
    if (exp_q.size() != 0 || fim_q.size() != 0) begin
      n_err += exp_q.size() + fim_q.size();
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size() + fim_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
